// File: rtl/button_debouncer.sv
// button_debouncer
//   Per-input debouncer for raw board buttons/switches. Each raw bit is
//   synchronized through two flops. A change is accepted only after the
//   synchronized value differs from the current level for STABLE_CYCLES
//   consecutive cycles. The accepted edge raises a one-cycle press or
//   release pulse.
//
//   Latency: if raw_i is first sampled at a new value on edge E and then held,
//   level_o changes on edge E+STABLE_CYCLES+1.
//
// Parameters
//   N_INPUTS      number of independent raw inputs
//   STABLE_CYCLES stable cycles required before a level change (>= 1)
//
// Ports
//   clk_i      clock, rising edge
//   rstn_i     synchronous active-low reset
//   raw_i      asynchronous raw inputs, active-high
//   level_o    debounced registered level per input
//   press_o    one-cycle pulse on each accepted 0->1 of level_o
//   release_o  one-cycle pulse on each accepted 1->0 of level_o
//
// Configuration
//   BUTTON_DEBOUNCER_RELEASE_PULSE_EN  when defined, release_o is generated;
//                                      otherwise release_o is tied to zero.

module button_debouncer #(
    parameter int unsigned N_INPUTS      = 4,
    parameter int unsigned STABLE_CYCLES = 1000000
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [N_INPUTS-1:0] raw_i,
    output logic [N_INPUTS-1:0] level_o,
    output logic [N_INPUTS-1:0] press_o,
    output logic [N_INPUTS-1:0] release_o
);

    localparam int unsigned    CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [N_INPUTS-1:0] sync1_q, sync1_d;
    logic [N_INPUTS-1:0] sync2_q, sync2_d;
    logic [N_INPUTS-1:0] level_q, level_d;
    logic [N_INPUTS-1:0] press_q, press_d;
    logic [CNT_W-1:0]    cnt_q [N_INPUTS];
    logic [CNT_W-1:0]    cnt_d [N_INPUTS];

`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
    logic [N_INPUTS-1:0] release_q, release_d;
`endif

    // Next-state: synchronizer shift, per-input stability counters, edge pulses
    always_comb begin
        sync1_d = raw_i;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = '0;
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
        release_d = '0;
`endif
        for (int unsigned i = 0; i < N_INPUTS; i++) begin
            // Any cycle matching the current level restarts the window
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    // Window complete: accept the new level, counter returns to 0
                    level_d[i] = sync2_q[i];
                    press_d[i] = sync2_q[i];
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
                    release_d[i] = ~sync2_q[i];
`endif
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int unsigned i = 0; i < N_INPUTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            for (int unsigned i = 0; i < N_INPUTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
    // Release pulse register, present only when the pulse is enabled
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            release_q <= '0;
        end else begin
            release_q <= release_d;
        end
    end

    assign release_o = release_q;
`else
    assign release_o = '0;
`endif

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (N_INPUTS=4, STABLE_CYCLES=4).
// Expected outputs are queued with the cycle they are due and checked on the
// falling edge of that cycle.

module tb_button_debouncer;

    localparam int unsigned N  = 4;
    localparam int unsigned SC = 4;

`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    typedef struct {
        int           cyc;
        string        tag;
        logic [N-1:0] level;
        logic [N-1:0] press;
        logic [N-1:0] rel;
    } exp_t;

    logic         clk;
    logic         rstn;
    logic [N-1:0] raw;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;

    int   cyc    = 0;
    int   tests  = 0;
    int   failed = 0;
    exp_t sb[$];

    button_debouncer #(
        .N_INPUTS      (N),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .raw_i     (raw),
        .level_o   (level),
        .press_o   (press),
        .release_o (rel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: compare every entry due in the current cycle
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                tests++;
                assert ({level, press, rel} === {sb[i].level, sb[i].press, sb[i].rel})
                else begin
                    failed++;
                    $error("FAIL %s cyc=%0d observed lvl=%b prs=%b rel=%b expected lvl=%b prs=%b rel=%b",
                           sb[i].tag, cyc, level, press, rel, sb[i].level, sb[i].press, sb[i].rel);
                end
                sb.delete(i);
            end
        end
    end

    // Press and release of one input must never coincide
    always @(negedge clk) begin
        if (cyc > 0) begin
            tests++;
            assert ((press & rel) === '0)
            else begin
                failed++;
                $error("FAIL press_release_overlap cyc=%0d observed press=%b release=%b expected no common bit",
                       cyc, press, rel);
            end
        end
    end

    task automatic expect_at(input int c, input string tag, input logic [N-1:0] lv,
                             input logic [N-1:0] pr, input logic [N-1:0] rl);
        exp_t e;
        e.cyc   = c;
        e.tag   = tag;
        e.level = lv;
        e.press = pr;
        e.rel   = REL_EN ? rl : '0;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int c;
        int guard;

        rstn = 1'b0;
        raw  = 4'b1111;
        @(negedge clk);

        // Reset with all inputs high, then a full window before acceptance
        c = cyc;
        expect_at(c + 1, "in_reset", 4'b0000, 4'b0000, 4'b0000);
        expect_at(c + 2, "in_reset", 4'b0000, 4'b0000, 4'b0000);
        tick(2);
        rstn = 1'b1;
        c = cyc;
        for (int k = 1; k <= 5; k++) expect_at(c + k, "post_reset_wait", 4'b0000, 4'b0000, 4'b0000);
        expect_at(c + 6, "post_reset_press", 4'b1111, 4'b1111, 4'b0000);
        expect_at(c + 7, "post_reset_hold", 4'b1111, 4'b0000, 4'b0000);
        tick(8);

        // Release all inputs
        c = cyc;
        raw = 4'b0000;
        expect_at(c + 5, "rel_all_wait", 4'b1111, 4'b0000, 4'b0000);
        expect_at(c + 6, "rel_all_edge", 4'b0000, 4'b0000, 4'b1111);
        expect_at(c + 7, "rel_all_hold", 4'b0000, 4'b0000, 4'b0000);
        tick(8);

        // Bounce on input 0: 2-cycle pulses are below the stability window
        for (int k = 0; k < 28; k++) begin
            raw[0] = (k < 20) ? (((k / 2) % 2) == 0) : 1'b0;
            expect_at(cyc + 1, "bounce", 4'b0000, 4'b0000, 4'b0000);
            tick(1);
        end

        // Clean press on input 2
        c = cyc;
        raw = 4'b0100;
        expect_at(c + 5, "press2_wait", 4'b0000, 4'b0000, 4'b0000);
        expect_at(c + 6, "press2_edge", 4'b0100, 4'b0100, 4'b0000);
        expect_at(c + 7, "press2_hold", 4'b0100, 4'b0000, 4'b0000);
        tick(8);

        // Release on input 2
        c = cyc;
        raw = 4'b0000;
        expect_at(c + 5, "rel2_wait", 4'b0100, 4'b0000, 4'b0000);
        expect_at(c + 6, "rel2_edge", 4'b0000, 4'b0000, 4'b0100);
        expect_at(c + 7, "rel2_hold", 4'b0000, 4'b0000, 4'b0000);
        tick(8);

        // Reset mid-count on input 1 discards the partial window
        c = cyc;
        raw = 4'b0010;
        for (int k = 1; k <= 3; k++) expect_at(c + k, "midcnt_pre", 4'b0000, 4'b0000, 4'b0000);
        tick(3);
        rstn = 1'b0;
        expect_at(c + 4, "midcnt_reset", 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        rstn = 1'b1;
        for (int k = 5; k <= 9; k++) expect_at(c + k, "midcnt_wait", 4'b0000, 4'b0000, 4'b0000);
        expect_at(c + 10, "midcnt_press", 4'b0010, 4'b0010, 4'b0000);
        expect_at(c + 11, "midcnt_hold", 4'b0010, 4'b0000, 4'b0000);
        tick(8);

        // Bring input 3 high as setup for the simultaneous case
        c = cyc;
        raw = 4'b1010;
        expect_at(c + 6, "press3_edge", 4'b1010, 4'b1000, 4'b0000);
        expect_at(c + 7, "press3_hold", 4'b1010, 4'b0000, 4'b0000);
        tick(8);

        // Input 0 rises and input 3 falls on the same edge
        c = cyc;
        raw = 4'b0011;
        expect_at(c + 5, "simul_wait", 4'b1010, 4'b0000, 4'b0000);
        expect_at(c + 6, "simul_edge", 4'b0011, 4'b0001, 4'b1000);
        expect_at(c + 7, "simul_hold", 4'b0011, 4'b0000, 4'b0000);
        tick(8);

        // Drain any outstanding expectations within a bounded number of cycles
        guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            tick(1);
            guard++;
        end
        tests++;
        assert (sb.size() == 0)
        else begin
            failed++;
            $error("FAIL scoreboard_drain observed %0d pending expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
